uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive-side byte buffer sitting directly downstream of the UART receiver. It captures each byte the receiver completes, as signalled by its done tick and data byte, into a first-word-fall-through FIFO. The CPU-facing UART register block drains it with single-cycle pop strobes. It decouples CPU read latency from line rate and flags overruns instead of silently overwriting data.

## Interface
Parameters:
- DEPTH, 16, number of byte entries; power of two, ≥ 2
- THRESH, 8, fill level for the interrupt (only with UART_RX_FIFO_IRQ_EN); 1 ≤ THRESH ≤ DEPTH

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low (0 = reset), deassertion synchronous to clk externally
- rx_done  input  1  receiver byte-complete tick; level or pulse, edge-detected internally
- rx_data  input  8  received byte, valid while rx_done is high
- rd_en  input  1  pop strobe from register block, one entry per high cycle
- clr_overrun  input  1  clears sticky overrun flag
- rd_data  output  8  head entry (FWFT); 8'h00 when empty
- empty  output  1  no entries stored
- full  output  1  count == DEPTH
- count  output  $clog2(DEPTH)+1  current occupancy
- overrun  output  1  sticky: a byte was dropped
- irq  output  1  fill/overrun interrupt (0 when feature compiled out)

## Operation
- Storage: DEPTH×8 register array, write pointer wp, read pointer rp (each $clog2(DEPTH) bits, natural wrap), occupancy counter cnt.
- Push detect: rx_done_q registered copy of rx_done; push = rx_done & ~rx_done_q. A rx_done held high for many cycles pushes exactly one byte.
- Pop: pop = rd_en & ~empty. rd_en on empty is ignored; no state change.
- Push accepted when ~full, or when full and pop in the same cycle (slot freed; cnt unchanged, both pointers advance).
- Push while full without pop: byte dropped, pointers/cnt unchanged, overrun set.
- Simultaneous push and pop when not full/empty: cnt unchanged, both pointers advance.
- Push into empty with rd_en high same cycle: pop ignored (empty), byte stored.
- overrun: set by dropped push; cleared by clr_overrun; set wins when both occur in the same cycle.
- rd_data = mem[rp] when ~empty, else 8'h00; combinational from registered state.
- empty = (cnt == 0), full = (cnt == DEPTH), count = cnt.

## Timing
- Reset (reset = 0, asynchronous): wp = rp = 0, cnt = 0, rx_done_q = 0, overrun = 0, irq = 0; outputs empty = 1, full = 0, count = 0, rd_data = 8'h00. Array contents not reset.
- Reset mid-operation discards all entries immediately; first push detected after release needs rx_done low→high relative to rx_done_q = 0 (a rx_done already high on release counts as an edge).
- Push latency: edge where rx_done first sampled high writes byte; next cycle empty = 0, count incremented, rd_data shows byte if it is the head.
- Pop latency: edge sampling rd_en advances rp; next cycle rd_data shows next entry, count decremented.
- Back-to-back pops every cycle supported; pushes at most one per rx_done rising edge (≥ 2 cycles apart).
- irq registered: updated one cycle after the cnt/overrun change that causes it.

## Configuration
- UART_RX_FIFO_IRQ_EN defined: irq = registered (cnt ≥ THRESH) | overrun; deasserts one cycle after pops bring cnt below THRESH and overrun is clear.
- Undefined: threshold logic absent, irq tied to 0, THRESH unused; all other behaviour identical.

## Test plan
- Reset then push 8'hA5 (rx_done 1-cycle pulse) -> next cycle empty = 0, count = 1, rd_data = 8'hA5; rd_en one cycle -> empty = 1, rd_data = 8'h00.
- rx_done held high 10 cycles with rx_data = 8'h3C -> count = 1 exactly.
- Push 17 bytes 0x00–0x10 into DEPTH = 16 -> full = 1, count = 16, overrun = 1; pops return 0x00–0x0F in order, 0x10 lost.
- Full FIFO, push 8'h77 with rd_en same cycle -> overrun stays 0, count = 16, popped 0x00, 8'h77 read last.
- Overrun set, assert clr_overrun together with another dropped push -> overrun remains 1; clr_overrun alone next cycle -> 0.
- With UART_RX_FIFO_IRQ_EN, THRESH = 8: 8th push -> irq = 1 one cycle later; one pop -> irq = 0 one cycle after count = 7; without macro irq stays 0 throughout.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte buffer between the UART receiver and the CPU register block.
// Each completed byte is captured on the rising edge of i_rx_done into a first-word-fall-through
// FIFO. The register block drains it with single-cycle pop strobes. A byte arriving while the
// FIFO is full, with no pop in the same cycle, is dropped and the sticky overrun flag is set.
//
// Optional feature: define UART_RX_FIFO_IRQ_EN to build the registered fill/overrun interrupt
// (irq = (count >= THRESH) | overrun). Without it, o_irq is tied low and THRESH is unused.
//
// Ports:
//   i_clk           system clock; all state changes on the rising edge
//   i_rst_n         asynchronous active-low reset
//   i_rx_done       receiver byte-complete tick (level or pulse; edge-detected here)
//   i_rx_data[7:0]  received byte, valid while i_rx_done is high
//   i_rd_en         pop strobe, one entry per high cycle
//   i_clr_overrun   clears the sticky overrun flag
//   o_rd_data[7:0]  head entry, 8'h00 when empty
//   o_empty         no entries stored
//   o_full          count == DEPTH
//   o_count         current occupancy
//   o_overrun       sticky: a byte was dropped
//   o_irq           fill/overrun interrupt (0 when the feature is compiled out)
module uart_rx_fifo #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned THRESH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_rx_done,
    input  logic [7:0]               i_rx_data,
    input  logic                     i_rd_en,
    input  logic                     i_clr_overrun,
    output logic [7:0]               o_rd_data,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overrun,
    output logic                     o_irq
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_cnt;
    logic          r_rx_done_q;
    logic          r_overrun;

    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_wr;
    logic          w_drop;
    logic [CW-1:0] w_cnt_d;

    assign w_empty = (r_cnt == '0);
    assign w_full  = (r_cnt == CW'(DEPTH));

    // A held-high done produces a single push.
    assign w_push  = i_rx_done & ~r_rx_done_q;
    assign w_pop   = i_rd_en & ~w_empty;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign w_wr    = w_push & (~w_full | w_pop);
    assign w_drop  = w_push & w_full & ~w_pop;

    always_comb begin
        w_cnt_d = r_cnt;
        unique case ({w_wr, w_pop})
            2'b10:   w_cnt_d = r_cnt + CW'(1);
            2'b01:   w_cnt_d = r_cnt - CW'(1);
            default: w_cnt_d = r_cnt;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wp        <= '0;
            r_rp        <= '0;
            r_cnt       <= '0;
            r_rx_done_q <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_rx_done_q <= i_rx_done;
            r_cnt       <= w_cnt_d;
            if (w_wr) begin
                r_wp <= r_wp + AW'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + AW'(1);
            end
            // Set has priority over clear so a drop is never lost.
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (i_clr_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wp] <= i_rx_data;
        end
    end

    assign o_rd_data = w_empty ? 8'h00 : r_mem[r_rp];
    assign o_empty   = w_empty;
    assign o_full    = w_full;
    assign o_count   = r_cnt;
    assign o_overrun = r_overrun;

`ifdef UART_RX_FIFO_IRQ_EN
    logic r_irq;

    // Built from registered state, so it trails the cnt/overrun change by one cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= (r_cnt >= CW'(THRESH)) | r_overrun;
        end
    end

    assign o_irq = r_irq;
`else
    assign o_irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a directed vector table, hand-written corner
// sequences and randomized traffic, all compared against a queue-based reference model.
module tb_uart_rx_fifo;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned THRESH = 8;
    localparam int unsigned CW     = $clog2(DEPTH) + 1;
`ifdef UART_RX_FIFO_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          rx_done;
    logic [7:0]    rx_data;
    logic          rd_en;
    logic          clr_ov;
    logic [7:0]    rd_data;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic          overrun;
    logic          irq;

    uart_rx_fifo #(
        .DEPTH  (DEPTH),
        .THRESH (THRESH)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_rx_done     (rx_done),
        .i_rx_data     (rx_data),
        .i_rd_en       (rd_en),
        .i_clr_overrun (clr_ov),
        .o_rd_data     (rd_data),
        .o_empty       (empty),
        .o_full        (full),
        .o_count       (count),
        .o_overrun     (overrun),
        .o_irq         (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: contents as a queue, plus the few flags the spec defines.
    logic [7:0] m_q[$];
    bit         m_prev;
    bit         m_ov;
    bit         m_irq;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_prev = 1'b0;
        m_ov   = 1'b0;
        m_irq  = 1'b0;
    endtask

    task automatic model_step(input bit d, input logic [7:0] dat, input bit rd, input bit clr);
        int sz;
        bit push;
        bit drop;
        bit nirq;
        sz   = m_q.size();
        push = d && !m_prev;
        nirq = (sz >= int'(THRESH)) || m_ov;
        drop = 1'b0;
        if (rd && sz > 0) void'(m_q.pop_front());
        if (push) begin
            if (m_q.size() < int'(DEPTH)) m_q.push_back(dat);
            else drop = 1'b1;
        end
        if (drop) m_ov = 1'b1;
        else if (clr) m_ov = 1'b0;
        m_irq  = IRQ_ON ? nirq : 1'b0;
        m_prev = d;
    endtask

    task automatic check_model();
        chk("empty", 32'(empty), 32'(m_q.size() == 0));
        chk("full", 32'(full), 32'(m_q.size() == int'(DEPTH)));
        chk("count", 32'(count), 32'(m_q.size()));
        chk("rd_data", 32'(rd_data), (m_q.size() == 0) ? 32'h0 : 32'(m_q[0]));
        chk("overrun", 32'(overrun), 32'(m_ov));
        chk("irq", 32'(irq), 32'(m_irq));
    endtask

    // One clock: drive inputs, clock edge, advance model, compare 1 time unit later.
    task automatic cyc(input bit d, input logic [7:0] dat, input bit rd, input bit clr);
        rx_done = d;
        rx_data = dat;
        rd_en   = rd;
        clr_ov  = clr;
        @(posedge clk);
        model_step(d, dat, rd, clr);
        #1;
        check_model();
    endtask

    // Asynchronous reset applied mid-cycle; outputs must clear before any edge.
    task automatic do_reset();
        rx_done = 1'b0;
        rd_en   = 1'b0;
        clr_ov  = 1'b0;
        rst_n   = 1'b0;
        #2;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit         done;
        logic [7:0] data;
        bit         rd;
        bit         clr;
        int         exp_cnt;
        logic [7:0] exp_rdd;
        bit         exp_ov;
    } vec_t;

    vec_t vecs[$];

    initial begin
        rst_n   = 1'b1;
        rx_done = 1'b0;
        rx_data = 8'h00;
        rd_en   = 1'b0;
        clr_ov  = 1'b0;
        @(posedge clk);
        #1;

        // ---- Directed table: single pulse push/pop, then held-high done ----
        vecs.push_back('{1, 8'hA5, 0, 0, 1, 8'hA5, 0});
        vecs.push_back('{0, 8'h00, 0, 0, 1, 8'hA5, 0});
        vecs.push_back('{0, 8'h00, 1, 0, 0, 8'h00, 0});
        vecs.push_back('{0, 8'h00, 1, 0, 0, 8'h00, 0});  // pop on empty ignored
        for (int i = 0; i < 10; i++) vecs.push_back('{1, 8'h3C, 0, 0, 1, 8'h3C, 0});
        vecs.push_back('{0, 8'h00, 0, 0, 1, 8'h3C, 0});
        vecs.push_back('{1, 8'h5A, 1, 0, 1, 8'h5A, 0});  // push and pop together
        vecs.push_back('{0, 8'h00, 1, 1, 0, 8'h00, 0});

        do_reset();
        foreach (vecs[i]) begin
            rx_done = vecs[i].done;
            rx_data = vecs[i].data;
            rd_en   = vecs[i].rd;
            clr_ov  = vecs[i].clr;
            @(posedge clk);
            model_step(vecs[i].done, vecs[i].data, vecs[i].rd, vecs[i].clr);
            #1;
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_cnt));
            chk($sformatf("vec%0d_rd_data", i), 32'(rd_data), 32'(vecs[i].exp_rdd));
            chk($sformatf("vec%0d_overrun", i), 32'(overrun), 32'(vecs[i].exp_ov));
        end

        // ---- 17 pushes into a 16-deep FIFO: last byte dropped ----
        do_reset();
        for (int i = 0; i < 17; i++) begin
            cyc(1, 8'(i), 0, 0);
            cyc(0, 8'h00, 0, 0);
        end
        chk("ovf_full", 32'(full), 32'd1);
        chk("ovf_count", 32'(count), 32'd16);
        chk("ovf_overrun", 32'(overrun), 32'd1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("ovf_pop%0d", i), 32'(rd_data), 32'(i));
            cyc(0, 8'h00, 1, 0);
        end
        chk("ovf_drained", 32'(empty), 32'd1);

        // ---- Full FIFO, push with simultaneous pop: no overrun ----
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cyc(1, 8'(i), 0, 0);
            cyc(0, 8'h00, 0, 0);
        end
        chk("fp_head", 32'(rd_data), 32'h00);
        cyc(1, 8'h77, 1, 0);
        chk("fp_overrun", 32'(overrun), 32'd0);
        chk("fp_count", 32'(count), 32'd16);
        cyc(0, 8'h00, 0, 0);
        for (int i = 1; i < 16; i++) begin
            chk($sformatf("fp_pop%0d", i), 32'(rd_data), 32'(i));
            cyc(0, 8'h00, 1, 0);
        end
        chk("fp_last", 32'(rd_data), 32'h77);
        cyc(0, 8'h00, 1, 0);
        chk("fp_empty", 32'(empty), 32'd1);

        // ---- Overrun: set beats clear, then clear alone ----
        for (int i = 0; i < 17; i++) begin
            cyc(1, 8'(8'h40 + i), 0, 0);
            cyc(0, 8'h00, 0, 0);
        end
        chk("clr_ov_set", 32'(overrun), 32'd1);
        cyc(1, 8'hEE, 0, 1);
        chk("clr_ov_setwins", 32'(overrun), 32'd1);
        cyc(0, 8'h00, 0, 1);
        chk("clr_ov_cleared", 32'(overrun), 32'd0);
        chk("clr_ov_count", 32'(count), 32'd16);

        // ---- Interrupt threshold timing ----
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cyc(1, 8'(8'h90 + i), 0, 0);
            if (i == 7) chk("irq_lag", 32'(irq), 32'd0);
            cyc(0, 8'h00, 0, 0);
        end
        chk("irq_count8", 32'(count), 32'd8);
        chk("irq_set", 32'(irq), 32'(IRQ_ON));
        cyc(0, 8'h00, 1, 0);
        chk("irq_count7", 32'(count), 32'd7);
        chk("irq_hold", 32'(irq), 32'(IRQ_ON));
        cyc(0, 8'h00, 0, 0);
        chk("irq_clear", 32'(irq), 32'd0);

        // ---- Randomized traffic against the model, alternating fill bias ----
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit rd;
            if ((i / 300) % 2 == 0) rd = ($urandom_range(0, 3) == 0);
            else rd = ($urandom_range(0, 3) != 0);
            cyc(1'($urandom_range(0, 1)), 8'($urandom), rd, ($urandom_range(0, 15) == 0));
        end

        // ---- Reset mid-operation discards contents; done high on release is an edge ----
        for (int i = 0; i < 5; i++) begin
            cyc(1, 8'(8'hB0 + i), 0, 0);
            cyc(0, 8'h00, 0, 0);
        end
        do_reset();
        cyc(1, 8'hC3, 0, 0);
        chk("rel_count", 32'(count), 32'd1);
        chk("rel_rd_data", 32'(rd_data), 32'hC3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
